// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the multi-channel frequency meter.
// Optional BCD readout is enabled with the FREQ_METER_BCD_EN macro.
package freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  // Decimal divisors applied to the base gate length by gate_sel.
  localparam int DEC_DIV [4] = '{1, 10, 100, 1000};

  // Gate length in clk cycles for a given gate_sel code.
  function automatic int gate_len(input int gate_cycles, input logic [1:0] sel);
    return gate_cycles / DEC_DIV[sel];
  endfunction

  // ceil(cnt_w * log10(2)) using a fixed-point approximation of log10(2).
  function automatic int bcd_digits(input int cnt_w);
    return (cnt_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/freq_bin2bcd.sv
// Sequential double-dabble binary to BCD converter (one bit per cycle).
// Only instantiated when FREQ_METER_BCD_EN is defined.
module freq_bin2bcd
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [CNT_W-1:0]                bin,
  output logic [4*bcd_digits(CNT_W)-1:0]  bcd,
  output logic                            valid
);

  localparam int DW = 4 * bcd_digits(CNT_W);
  localparam int CW = $clog2(CNT_W);

  logic [DW-1:0]    acc_q, acc_d, adj;
  logic [CNT_W-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             act_q, act_d;
  logic [DW-1:0]    out_q, out_d;
  logic             valid_q, valid_d;

  assign bcd   = out_q;
  assign valid = valid_q;

  // Add 3 to every digit that is 5 or more before the next shift.
  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DW / 4; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
  end

  // Load performs the first shift, so the result lands CNT_W cycles after start.
  always_comb begin
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    out_d   = out_q;
    valid_d = 1'b0;
    if (start) begin
      acc_d = {{(DW-1){1'b0}}, bin[CNT_W-1]};
      sh_d  = bin << 1;
      cnt_d = CW'(CNT_W - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      acc_d = {adj[DW-2:0], sh_q[CNT_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        act_d   = 1'b0;
        out_d   = acc_d;
        valid_d = 1'b1;
      end
    end
  end

  // Converter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/freq_edge_counter.sv
// One measurement channel: synchroniser, rising-edge detect,
// saturating edge counter and the latched result/overflow registers.
module freq_edge_counter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wave_in,
  input  logic             clear,
  input  logic             count_en,
  input  logic             terminal,
  output logic [CNT_W-1:0] result,
  output logic             ovf
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       result_q, result_d;
  logic                   ovf_run_q, ovf_run_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_pulse;
  logic                   cnt_full;

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign cnt_full   = &cnt_q;
  assign result     = result_q;
  assign ovf        = ovf_q;

  // Synchroniser shift and previous-sample for edge detection.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], wave_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Saturating edge count; on the terminal cycle the in-flight edge is folded into the result.
  always_comb begin
    cnt_d     = cnt_q;
    ovf_run_d = ovf_run_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    if (clear) begin
      cnt_d     = '0;
      ovf_run_d = 1'b0;
    end else if (count_en) begin
      if (terminal) begin
        result_d  = cnt_full ? cnt_q : cnt_q + CNT_W'(edge_pulse);
        ovf_d     = ovf_run_q | (cnt_full & edge_pulse);
        cnt_d     = '0;
        ovf_run_d = 1'b0;
      end else if (edge_pulse) begin
        if (cnt_full) ovf_run_d = 1'b1;
        else          cnt_d     = cnt_q + CNT_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      ovf_run_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      ovf_run_q <= ovf_run_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: rtl/freq_meter_multi.sv
// Multi-channel frequency meter: shared gate FSM, NUM_CH edge counters,
// readout mux. Define FREQ_METER_BCD_EN to add the rd_bcd/bcd_valid readout.
// Handshake: start is a one-cycle request taken only in IDLE; meas_valid is a
// one-cycle pulse with no back-pressure, results stay stable for a whole window.
module freq_meter_multi
  import freq_meter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_CH-1:0]                              waveform,
  input  logic [1:0]                                     gate_sel,
  input  logic                                           run,
  input  logic                                           start,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  output logic [CNT_W-1:0]                               rd_count,
  output logic                                           rd_ovf,
  output logic [1:0]                                     gate_sel_q,
  output logic                                           meas_valid,
  output logic                                           busy,
  output logic                                           dbg_state
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [4*bcd_digits(CNT_W)-1:0]                 rd_bcd,
  output logic                                           bcd_valid
`endif
);

  localparam int GCW = $clog2(GATE_CYCLES);

  state_e                  state_q, state_d;
  logic [GCW-1:0]          gcnt_q, gcnt_d;
  logic [1:0]              gsel_q, gsel_d;
  logic [1:0]              res_gsel_q, res_gsel_d;
  logic                    meas_valid_q, meas_valid_d;
  logic                    clear, terminal, in_gate;
  logic [NUM_CH-1:0][CNT_W-1:0] ch_result;
  logic [NUM_CH-1:0]            ch_ovf;

  // Gate counter reload value (length - 1); all four options are constants.
  function automatic logic [GCW-1:0] gate_load(input logic [1:0] sel);
    logic [GCW-1:0] r;
    case (sel)
      2'd0:    r = GCW'(gate_len(GATE_CYCLES, 2'd0) - 1);
      2'd1:    r = GCW'(gate_len(GATE_CYCLES, 2'd1) - 1);
      2'd2:    r = GCW'(gate_len(GATE_CYCLES, 2'd2) - 1);
      default: r = GCW'(gate_len(GATE_CYCLES, 2'd3) - 1);
    endcase
    return r;
  endfunction

  assign gate_sel_q = res_gsel_q;
  assign meas_valid = meas_valid_q;
  assign busy       = (state_q == GATE);
  assign dbg_state  = (state_q == GATE);

  // Gate FSM: next state, gate counter and window strobes.
  always_comb begin
    state_d      = state_q;
    gcnt_d       = gcnt_q;
    gsel_d       = gsel_q;
    res_gsel_d   = res_gsel_q;
    clear        = 1'b0;
    terminal     = 1'b0;
    in_gate      = 1'b0;
    case (state_q)
      IDLE: begin
        if (run || start) begin
          state_d = GATE;
          gsel_d  = gate_sel;
          gcnt_d  = gate_load(gate_sel);
          clear   = 1'b1;
        end
      end
      GATE: begin
        in_gate = 1'b1;
        if (gcnt_q == '0) begin
          terminal   = 1'b1;
          res_gsel_d = gsel_q;
          if (run) begin
            gsel_d = gate_sel;
            gcnt_d = gate_load(gate_sel);
          end else begin
            state_d = IDLE;
          end
        end else begin
          gcnt_d = gcnt_q - GCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    meas_valid_d = terminal;
  end

  // FSM and gate registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gcnt_q       <= '0;
      gsel_q       <= '0;
      res_gsel_q   <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gcnt_q       <= gcnt_d;
      gsel_q       <= gsel_d;
      res_gsel_q   <= res_gsel_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_edge_counter #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cnt (
      .clk     (clk),
      .rst     (reset),
      .wave_in (waveform[g]),
      .clear   (clear),
      .count_en(in_gate),
      .terminal(terminal),
      .result  (ch_result[g]),
      .ovf     (ch_ovf[g])
    );
  end

  // Readout mux; out-of-range selects read as zero.
  always_comb begin
    rd_count = '0;
    rd_ovf   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rd_ch) == i) begin
        rd_count = ch_result[i];
        rd_ovf   = ch_ovf[i];
      end
    end
  end

`ifdef FREQ_METER_BCD_EN
  freq_bin2bcd #(.CNT_W(CNT_W)) u_bcd (
    .clk  (clk),
    .rst  (reset),
    .start(meas_valid_q),
    .bin  (rd_count),
    .bcd  (rd_bcd),
    .valid(bcd_valid)
  );
`endif

endmodule

// File: tb/tb_freq_meter_multi.sv
// Bench for freq_meter_multi: window-level reference model compared every
// cycle, plus directed literal checks (periods, overflow, start/reset, gate_sel).
module tb_freq_meter_multi;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 24;
  localparam int GATE_CYCLES = 1000;
  localparam int SYNC_STAGES = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main DUT signals
  logic [NUM_CH-1:0] waveform;
  logic [1:0]        gate_sel;
  logic              run, start;
  logic [1:0]        rd_ch;
  logic [CNT_W-1:0]  rd_count;
  logic              rd_ovf, meas_valid, busy, dbg_state;
  logic [1:0]        gate_sel_q;

  // narrow-counter DUT signals
  logic       w4, run4, start4, rd_ch4;
  logic [1:0] gs4;
  logic [3:0] rd_count4;
  logic       rd_ovf4, mv4, busy4, dbg4;
  logic [1:0] gsq4;

`ifdef FREQ_METER_BCD_EN
  logic [31:0] rd_bcd;
  logic        bcd_valid;
  logic [7:0]  rd_bcd4;
  logic        bcd_valid4;
`endif

  freq_meter_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .waveform(waveform), .gate_sel(gate_sel), .run(run),
    .start(start), .rd_ch(rd_ch), .rd_count(rd_count), .rd_ovf(rd_ovf),
    .gate_sel_q(gate_sel_q), .meas_valid(meas_valid), .busy(busy), .dbg_state(dbg_state)
`ifdef FREQ_METER_BCD_EN
    , .rd_bcd(rd_bcd), .bcd_valid(bcd_valid)
`endif
  );

  freq_meter_multi #(
    .NUM_CH(1), .CNT_W(4), .GATE_CYCLES(GATE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut4 (
    .clk(clk), .reset(reset), .waveform(w4), .gate_sel(gs4), .run(run4),
    .start(start4), .rd_ch(rd_ch4), .rd_count(rd_count4), .rd_ovf(rd_ovf4),
    .gate_sel_q(gsq4), .meas_valid(mv4), .busy(busy4), .dbg_state(dbg4)
`ifdef FREQ_METER_BCD_EN
    , .rd_bcd(rd_bcd4), .bcd_valid(bcd_valid4)
`endif
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // ---------------- reference model (window level) ----------------
  // A rise sampled at edge k reaches the counter at edge k+SYNC_STAGES.
  // The window is the set of edges at which the meter is gating.
  function automatic int win_len(input int sel);
    int div = 1;
    repeat (sel) div *= 10;
    return GATE_CYCLES / div;
  endfunction

  int unsigned       m_acc [NUM_CH];
  int unsigned       m_res [NUM_CH];
  bit                m_ovf [NUM_CH];
  bit                m_gate, m_mv;
  int                m_rem, m_gsel, m_gsq;
  logic [NUM_CH-1:0] w_hist [SYNC_STAGES+2];
  localparam int unsigned MAXC = (1 << CNT_W) - 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin m_acc[c] = 0; m_res[c] = 0; m_ovf[c] = 0; end
      for (int i = 0; i < SYNC_STAGES + 2; i++) w_hist[i] = '0;
      m_gate = 0; m_mv = 0; m_rem = 0; m_gsel = 0; m_gsq = 0;
    end else begin
      for (int i = SYNC_STAGES + 1; i > 0; i--) w_hist[i] = w_hist[i-1];
      w_hist[0] = waveform;
      m_mv = 0;
      if (m_gate) begin
        for (int c = 0; c < NUM_CH; c++)
          if (w_hist[SYNC_STAGES][c] && !w_hist[SYNC_STAGES+1][c]) m_acc[c]++;
        if (m_rem == 0) begin
          for (int c = 0; c < NUM_CH; c++) begin
            m_res[c] = (m_acc[c] > MAXC) ? MAXC : m_acc[c];
            m_ovf[c] = (m_acc[c] > MAXC);
            m_acc[c] = 0;
          end
          m_mv  = 1;
          m_gsq = m_gsel;
          if (run) begin m_gsel = int'(gate_sel); m_rem = win_len(m_gsel) - 1; end
          else m_gate = 0;
        end else begin
          m_rem--;
        end
      end else if (run || start) begin
        m_gate = 1;
        m_gsel = int'(gate_sel);
        m_rem  = win_len(m_gsel) - 1;
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    check("busy", busy, m_gate);
    check("dbg_state", dbg_state, m_gate);
    check("meas_valid", meas_valid, m_mv);
    check("gate_sel_q", gate_sel_q, m_gsq);
    check("rd_count", rd_count, m_res[rd_ch]);
    check("rd_ovf", rd_ovf, m_ovf[rd_ch]);
  end

  // ---------------- waveform driver ----------------
  int per [NUM_CH] = '{0, 0, 0, 0};
  int per4 = 0;
  bit rnd_wave = 0;
  int cyc = 0;

  initial begin
    waveform = '0;
    w4 = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rnd_wave) begin
          if ($urandom_range(0, 2) == 0) waveform[c] = ~waveform[c];
        end else begin
          waveform[c] = (per[c] != 0) && ((cyc % per[c]) < per[c] / 2);
        end
      end
      w4 = (per4 != 0) && ((cyc % per4) < per4 / 2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_mv(input int budget, output int waited);
    waited = 0;
    do begin step(); waited++; end while (!meas_valid && waited < budget);
    if (!meas_valid) check("meas_valid timeout", meas_valid, 1);
  endtask

  // watchdog
  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
    $finish;
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int wt, sum2, bcnt, mcnt;
    logic [CNT_W-1:0] v [NUM_CH];

    reset = 1; run = 0; start = 0; gate_sel = 0; rd_ch = 0;
    run4 = 0; start4 = 0; gs4 = 0; rd_ch4 = 0;
    repeat (3) step();
    check("reset rd_count", rd_count, 0);
    check("reset busy", busy, 0);
    check("reset gate_sel_q", gate_sel_q, 0);
    reset = 0;

    // 40-cycle period on ch0; narrow DUT sees a 20-cycle period
    per[0] = 40; per4 = 20;
    repeat (5) step();
    run = 1; run4 = 1;
    wait_mv(1200, wt);
    check("t1 ch0 count", rd_count, 25);
    check("t1 ch0 ovf", rd_ovf, 0);
    check("t1 cnt4 saturated", rd_count4, 15);
    check("t1 cnt4 ovf", rd_ovf4, 1);
    per4 = 0;
    wait_mv(1200, wt);
    check("t1 window period", wt, 1000);
    check("t1 ch0 count w2", rd_count, 25);
    wait_mv(1200, wt);
    check("t1 window period w3", wt, 1000);
    check("t1 cnt4 static", rd_count4, 0);
    check("t1 cnt4 ovf clear", rd_ovf4, 0);
    run4 = 0;
`ifdef FREQ_METER_BCD_EN
    wt = 0;
    while (!bcd_valid && wt < 100) begin step(); wt++; end
    check("bcd latency", wt, CNT_W);
    check("bcd value", rd_bcd, 32'h25);
`endif

    // four channels, continuous; ch2 sum over 13 windows
    per = '{40, 50, 130, 20};
    wait_mv(1200, wt);
    wait_mv(1200, wt);
    sum2 = 0;
    for (int w = 0; w < 13; w++) begin
      wait_mv(1200, wt);
      for (int c = 0; c < NUM_CH; c++) begin
        step(); rd_ch = 2'(c); #1; v[c] = rd_count;
      end
      check("t2 ch0", v[0], 25);
      check("t2 ch1", v[1], 20);
      check("t2 ch2 7or8", (v[2] == 7 || v[2] == 8), 1);
      check("t2 ch3", v[3], 50);
      sum2 += int'(v[2]);
    end
    check("t2 ch2 sum13", sum2, 100);

    // gate_sel change mid-gate
    rd_ch = 0;
    repeat (400) step();
    gate_sel = 1;
    wait_mv(1200, wt);
    check("t3 old window count", rd_count, 25);
    check("t3 old gate_sel_q", gate_sel_q, 0);
    wait_mv(1200, wt);
    check("t3 short window len", wt, 100);
    check("t3 short count 2or3", (rd_count == 2 || rd_count == 3), 1);
    check("t3 new gate_sel_q", gate_sel_q, 1);

    // run dropped mid-gate: current gate completes, then idle
    gate_sel = 0; run = 0;
    wait_mv(1200, wt);
    check("t5 idle after run drop", busy, 0);

    // single start, second start ignored while busy
    repeat (10) step();
    start = 1; step(); start = 0;
    bcnt = 0; mcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (busy) bcnt++;
      if (meas_valid) mcnt++;
      if (!busy) break;
      start = (i == 300);
      step();
    end
    start = 0;
    repeat (20) begin step(); if (meas_valid) mcnt++; end
    check("t5 busy cycles", bcnt, 1000);
    check("t5 one meas_valid", mcnt, 1);

    // reset at cycle 500 of a gate
    start = 1; step(); start = 0;
    repeat (499) step();
    check("t5 pre-reset result", rd_count, 25);
    reset = 1; #1;
    check("t5 reset rd_count", rd_count, 0);
    check("t5 reset busy", busy, 0);
    check("t5 reset meas_valid", meas_valid, 0);
    repeat (3) step();
    reset = 0;
    mcnt = 0; bcnt = 0;
    repeat (1100) begin step(); if (meas_valid) mcnt++; if (busy) bcnt++; end
    check("t5 no mv after reset", mcnt, 0);
    check("t5 no busy after reset", bcnt, 0);

    // randomized mixed operation
    rnd_wave = 1; run = 1;
    for (int i = 0; i < 8000; i++) begin
      step();
      rd_ch = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) gate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 799) == 0) run = ~run;
      start = ($urandom_range(0, 149) == 0);
    end

    // gate length 1: meas_valid held high in run mode
    start = 0; run = 1; gate_sel = 3;
    wait_mv(1200, wt);
    for (int i = 0; i < 20; i++) begin
      step();
      check("t6 continuous meas_valid", meas_valid, 1);
    end
    run = 0;
    repeat (5) step();

    report();
    $finish;
  end

endmodule
